// File: rtl/uart_rx_if.sv
// uart_rx output bundle: received byte, strobes and busy flag.
// The receiver drives it through master, the consumer reads through slave.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output rx_busy
   );

   modport slave (
      input rx_data,
      input rx_valid,
      input frame_err,
      input rx_busy
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start check at mid-bit, centre-sampled data bits.
// UART_RX_MAJORITY_EN: 2-of-3 majority vote on every sample.
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      rx_pin,
   uart_rx_if.master rx
);

   function integer clog2;
      input integer v;
      integer t;
      begin
         clog2 = 0;
         t = v - 1;
         while (t > 0) begin
            clog2 = clog2 + 1;
            t = t >> 1;
         end
      end
   endfunction

   localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int HALF_DIV = BAUD_DIV / 2;
   localparam int CNT_W    = clog2(BAUD_DIV);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK_WAIT
   } state_t;

   state_t           state, state_nxt;
   logic             s1, rx_s, smp;
   logic [CNT_W-1:0] baud_cnt, cnt_nxt;
   logic [2:0]       bit_idx, bit_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic [7:0]       data_q, data_nxt;
   logic             valid_q, valid_nxt;
   logic             err_q, err_nxt;
   logic             busy;
   logic             half_hit, full_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         s1   <= rx_pin;
         rx_s <= s1;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // Two delayed copies of rx_s give target-2 / target-1 at the target count
   logic h1, h2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h1 <= 1'b1;
         h2 <= 1'b1;
      end else begin
         h1 <= rx_s;
         h2 <= h1;
      end
   end

   assign smp = (h1 & h2) | (h1 & rx_s) | (h2 & rx_s);
`else
   assign smp = rx_s;
`endif

   assign busy     = (state != IDLE);
   assign half_hit = (baud_cnt == CNT_W'(HALF_DIV - 1));
   assign full_hit = (baud_cnt == CNT_W'(BAUD_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= cnt_nxt;
         bit_idx  <= bit_nxt;
         shreg    <= shreg_nxt;
         data_q   <= data_nxt;
         valid_q  <= valid_nxt;
         err_q    <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = busy ? baud_cnt + CNT_W'(1) : '0;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      data_nxt  = data_q;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rx_s) state_nxt = START;
         end
         START: begin
            if (half_hit) begin
               state_nxt = smp ? IDLE : DATA;
               bit_nxt   = '0;
            end
         end
         DATA: begin
            if (full_hit) begin
               shreg_nxt = {smp, shreg[7:1]};
               bit_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (full_hit) begin
               if (smp) begin
                  data_nxt  = shreg;
                  valid_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = BRK_WAIT;
               end
            end
         end
         BRK_WAIT: begin
            // A held-low break must not look like a fresh start bit
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
   end

   assign rx.rx_data   = data_q;
   assign rx.rx_valid  = valid_q;
   assign rx.frame_err = err_q;
   assign rx.rx_busy   = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a 16x baud divider.
// Frames are driven on rx_pin by a behavioural transmitter task.
module tb_uart_rx;

   localparam int  CLK_FREQ  = 1_600_000;
   localparam int  BAUD_RATE = 100_000;
   localparam int  DIV       = 16;
   localparam int  HALF      = 8;
   localparam int  LAT       = 3 + HALF + 9 * DIV + 1;
   localparam real BIT       = 160.0;
   localparam real BIT_FAST  = BIT / 1.02;
`ifdef UART_RX_MAJORITY_EN
   localparam bit  GLITCH    = 1'b1;
`else
   localparam bit  GLITCH    = 1'b0;
`endif

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic rx_pin = 1'b1;

   uart_rx_if ifc ();

   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx_pin(rx_pin),
      .rx    (ifc)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int vcnt = 0, ecnt = 0, both = 0, busy_cyc = 0, bad_chg = 0;
   logic [7:0] rxq[$];
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      if (ifc.rx_valid) begin
         vcnt <= vcnt + 1;
         rxq.push_back(ifc.rx_data);
      end
      if (ifc.frame_err) ecnt <= ecnt + 1;
      if (ifc.rx_valid && ifc.frame_err) both <= both + 1;
      if (ifc.rx_busy) busy_cyc <= busy_cyc + 1;
      if (rst_n && ifc.rx_data !== prev_data && !ifc.rx_valid)
         bad_chg <= bad_chg + 1;
      prev_data <= ifc.rx_data;
   end

   task automatic send(input logic [7:0] b, input real bt,
                       input logic stop, input bit glitch);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_pin = f[i];
         if (glitch) begin
            #(bt / 2.0);
            rx_pin = ~f[i];
            #10;
            rx_pin = f[i];
            #(bt / 2.0 - 10.0);
         end else begin
            #(bt);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle(3);
      tests++;
      if ({ifc.rx_data, ifc.rx_valid, ifc.frame_err, ifc.rx_busy} !== 11'h0) begin
         fails++;
         $display("FAIL reset_outputs: got data=%h v=%b e=%b b=%b, want 00/0/0/0",
                  ifc.rx_data, ifc.rx_valid, ifc.frame_err, ifc.rx_busy);
      end
      rst_n = 1'b1;
      idle(5);
      tests++;
      if (ifc.rx_busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle_busy: got %b, want 0", ifc.rx_busy);
      end
   endtask

   task automatic test_single;
      int v0, e0, lat;
      v0 = vcnt;
      e0 = ecnt;
      lat = -1;
      rxq.delete();
      @(negedge clk);
      fork
         send(8'h55, BIT, 1'b1, 1'b0);
         begin
            for (int i = 0; i < LAT + 40; i++) begin
               @(negedge clk);
               if (ifc.rx_valid && lat < 0) lat = i + 1;
            end
         end
      join
      idle(2 * DIV);
      tests++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
         fails++;
         $display("FAIL single_latency: got %0d cycles, want %0d+-1", lat, LAT);
      end
      tests++;
      if (vcnt - v0 != 1 || rxq.size() < 1 || rxq[0] !== 8'h55) begin
         fails++;
         $display("FAIL single_data: got %0d pulses, first byte %h, want 1 pulse 55",
                  vcnt - v0, rxq.size() > 0 ? rxq[0] : 8'hxx);
      end
      tests++;
      if (ecnt != e0 || ifc.rx_data !== 8'h55) begin
         fails++;
         $display("FAIL single_hold: got err=%0d data=%h, want err=0 data=55",
                  ecnt - e0, ifc.rx_data);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] vals[4];
      int v0, e0;
      vals = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
      v0 = vcnt;
      e0 = ecnt;
      rxq.delete();
      for (int i = 0; i < 4; i++) send(vals[i], BIT, 1'b1, 1'b0);
      idle(2 * DIV);
      tests++;
      if (vcnt - v0 != 4 || ecnt != e0) begin
         fails++;
         $display("FAIL b2b_count: got %0d valid %0d err, want 4 valid 0 err",
                  vcnt - v0, ecnt - e0);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (rxq.size() <= i || rxq[i] !== vals[i]) begin
            fails++;
            $display("FAIL b2b_byte%0d: got %h, want %h", i,
                     rxq.size() > i ? rxq[i] : 8'hxx, vals[i]);
         end
      end
   endtask

   task automatic test_glitch;
      int v0, e0, b0;
      v0 = vcnt;
      e0 = ecnt;
      b0 = busy_cyc;
      @(negedge clk);
      rx_pin = 1'b0;
      idle(HALF / 2);
      rx_pin = 1'b1;
      idle(3 * DIV);
      tests++;
      if (vcnt != v0 || ecnt != e0) begin
         fails++;
         $display("FAIL glitch_output: got %0d valid %0d err, want 0 0",
                  vcnt - v0, ecnt - e0);
      end
      tests++;
      if (busy_cyc - b0 < HALF - 1 || busy_cyc - b0 > HALF + 1 || ifc.rx_busy !== 1'b0) begin
         fails++;
         $display("FAIL glitch_busy: got %0d busy cycles, busy now %b, want %0d+-1 then 0",
                  busy_cyc - b0, ifc.rx_busy, HALF);
      end
   endtask

   task automatic test_frame_err;
      int v0, e0;
      logic [7:0] d0;
      v0 = vcnt;
      e0 = ecnt;
      d0 = ifc.rx_data;
      send(8'h81, BIT, 1'b0, 1'b0);
      #(2.0 * BIT);
      tests++;
      if (ifc.rx_busy !== 1'b1) begin
         fails++;
         $display("FAIL break_busy: got %b, want 1", ifc.rx_busy);
      end
      rx_pin = 1'b1;
      idle(12 * DIV);
      tests++;
      if (ecnt - e0 != 1 || vcnt != v0 || ifc.rx_data !== d0) begin
         fails++;
         $display("FAIL frame_err: got %0d err %0d valid data=%h, want 1 0 %h",
                  ecnt - e0, vcnt - v0, ifc.rx_data, d0);
      end
      rxq.delete();
      send(8'h42, BIT, 1'b1, 1'b0);
      idle(2 * DIV);
      tests++;
      if (vcnt - v0 != 1 || rxq.size() != 1 || rxq[0] !== 8'h42) begin
         fails++;
         $display("FAIL after_break: got %0d valid, byte %h, want 1 42",
                  vcnt - v0, rxq.size() > 0 ? rxq[0] : 8'hxx);
      end
   endtask

   task automatic test_reset_abort;
      int v0;
      v0 = vcnt;
      rx_pin = 1'b0;
      #(BIT);
      for (int i = 0; i < 4; i++) #(BIT);
      rx_pin = 1'b1;
      #(BIT / 2.0);
      rst_n = 1'b0;
      idle(3);
      tests++;
      if ({ifc.rx_data, ifc.rx_valid, ifc.frame_err, ifc.rx_busy} !== 11'h0) begin
         fails++;
         $display("FAIL abort_reset_vals: got data=%h v=%b e=%b b=%b, want 00/0/0/0",
                  ifc.rx_data, ifc.rx_valid, ifc.frame_err, ifc.rx_busy);
      end
      rst_n = 1'b1;
      idle(8 * DIV);
      tests++;
      if (vcnt != v0) begin
         fails++;
         $display("FAIL abort_no_output: got %0d valid, want 0", vcnt - v0);
      end
      rxq.delete();
      send(8'h0F, BIT, 1'b1, 1'b0);
      idle(2 * DIV);
      tests++;
      if (vcnt - v0 != 1 || rxq.size() != 1 || rxq[0] !== 8'h0F) begin
         fails++;
         $display("FAIL abort_next: got %0d valid, byte %h, want 1 0F",
                  vcnt - v0, rxq.size() > 0 ? rxq[0] : 8'hxx);
      end
   endtask

   task automatic test_loopback;
      logic [7:0] exp[$];
      logic [7:0] b;
      int v0, e0;
      v0 = vcnt;
      e0 = ecnt;
      rxq.delete();
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom);
         exp.push_back(b);
         send(b, BIT_FAST, 1'b1, GLITCH);
      end
      idle(2 * DIV);
      tests++;
      if (vcnt - v0 != 256 || ecnt != e0) begin
         fails++;
         $display("FAIL loop_count: got %0d valid %0d err, want 256 0",
                  vcnt - v0, ecnt - e0);
      end
      for (int i = 0; i < 256; i++) begin
         tests++;
         if (rxq.size() <= i || rxq[i] !== exp[i]) begin
            fails++;
            $display("FAIL loop_byte%0d: got %h, want %h", i,
                     rxq.size() > i ? rxq[i] : 8'hxx, exp[i]);
         end
      end
   endtask

   task automatic test_invariants;
      tests++;
      if (both != 0 || bad_chg != 0) begin
         fails++;
         $display("FAIL invariants: got %0d overlaps %0d stray data changes, want 0 0",
                  both, bad_chg);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_abort();
      test_loopback();
      test_invariants();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
